endec_sched: RTL and testbench
==============================

Name: endec_sched

Overview:
- Controller that shares one endec engine between an encode requester and a decode requester.
- Arbitrates between the two, flushes the engine before each job, and sequences it.
- Encode jobs: feeds payload bits serially and assembles the coded output.
- Decode jobs: presents the received frame and captures the decoded output.
- Sits between the system-side request/response interfaces and the endec engine ports.

Parameters:
- FRAME_LEN, 16: data frame length in bits (decoder output width, encoder payload width).
- CODE_RATE, 2: coded bits per input bit (encoder output width per step).
- TB_DEPTH, 32: decoder input frame width; must equal FRAME_LEN*CODE_RATE.
- TIMEOUT, 64: maximum cycles to wait for an engine done pulse before aborting the job.

Ports:
- sys_clk  in  1  system clock (single clock domain).
- rst  in  1  asynchronous active-low reset.
- i_enc_req_valid  in  1  encode request valid.
- o_enc_req_ready  out  1  encode request accepted when valid&&ready.
- i_enc_req_data  in  FRAME_LEN  payload to encode, MSB sent first.
- o_enc_rsp_valid  out  1  encode response valid.
- i_enc_rsp_ready  in  1  encode response consumed when valid&&ready.
- o_enc_rsp_data  out  FRAME_LEN*CODE_RATE  coded output; first bit's pair in MSBs.
- o_enc_rsp_err  out  1  job aborted by timeout.
- i_dec_req_valid  in  1  decode request valid.
- o_dec_req_ready  out  1  decode request accepted.
- i_dec_req_data  in  TB_DEPTH  received frame.
- o_dec_rsp_valid  out  1  decode response valid.
- i_dec_rsp_ready  in  1  decode response consumed.
- o_dec_rsp_data  out  FRAME_LEN  decoded frame.
- o_dec_rsp_err  out  1  job aborted by timeout.
- o_eng_rst_n  out  1  engine reset; equals rst AND NOT flush.
- o_eng_en  out  1  engine enable.
- o_eng_mode_sel  out  1  0 = encode, 1 = decode.
- o_eng_encoder_bit  out  1  current payload bit.
- o_eng_decoder_data_frame  out  TB_DEPTH  registered copy of the decode frame.
- i_eng_encoder_data  in  CODE_RATE  engine coded bits.
- i_eng_encoder_done  in  1  one-cycle pulse: coded bits valid.
- i_eng_decoder_data  in  FRAME_LEN  engine decoded frame.
- i_eng_decoder_done  in  1  one-cycle pulse: decoded frame valid.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; o_eng_rst_n is 0 while rst is low; state = IDLE; last_grant = DEC.
- State machine: IDLE, FLUSH, ENC_RUN, DEC_RUN, RESP.
- IDLE → FLUSH (grant):
  - Ready is combinational, high only in IDLE and only for the granted side.
  - Grant goes to the single valid requester; if both are valid, grant the side opposite last_grant.
  - On accept, latch the payload or frame, set o_eng_mode_sel, update last_grant, go to FLUSH.
- FLUSH (1 cycle): o_eng_en=0 and flush=1 so o_eng_rst_n=0. Next state is ENC_RUN or DEC_RUN.
- ENC_RUN:
  - o_eng_en=1; o_eng_encoder_bit = payload[FRAME_LEN-1-idx].
  - On i_eng_encoder_done: shift the response register left by CODE_RATE, insert i_eng_encoder_data, idx++, clear timer.
  - The done that captures idx==FRAME_LEN-1 goes to RESP.
- DEC_RUN: o_eng_en=1 and the frame is driven; on i_eng_decoder_done, capture i_eng_decoder_data and go to RESP.
- Timer:
  - Counts cycles in a RUN state since entry or since the last done.
  - When the count reaches TIMEOUT-1 with no done, go to RESP with err=1 and data forced to 0.
  - Done and timeout in the same cycle: done wins.
- RESP:
  - o_eng_en=0.
  - The matching rsp_valid stays high with data/err stable until rsp_ready, then IDLE.
  - No new request is accepted while in RESP.
- Minimum path: response valid in the cycle after the final done is captured.
  - Encode with done one cycle after each bit: accept at c0, rsp_valid at c18.
- Done pulses outside the matching RUN state are ignored; rsp_ready without rsp_valid is ignored.
- o_eng_mode_sel holds the last job's value between jobs.
- Reset mid-job: immediate return to reset values; the in-flight job and any pending response are discarded.

Decomposition:
- Add to the shared param_def.v:
  - MODE_ENC=1'b0 and MODE_DEC=1'b1.
  - State encodings.
  - Default FRAME_LEN, CODE_RATE, TB_DEPTH, TIMEOUT macros consistent with the existing DATA_FRAME_LENGTH, MAX_CODE_RATE and TRACEBACK_DEPTH.
- One sub-module: endec_sched_arb, a 2-way round-robin arbiter holding last_grant, producing grant and ready.

Test Plan:
- Encode, model engine returns {b,~b} with done 1 cycle after each bit; payload 16'hA5C3 → o_enc_rsp_data=32'h9966A55A, err=0, accept c0 → valid c18.
- Decode, model returns 16'h1234 with done on the 5th DEC_RUN cycle → o_dec_rsp_data=16'h1234, err=0, valid 7 cycles after accept; o_eng_rst_n low exactly 1 cycle (c1).
- Both requests held valid continuously from reset → grants alternate ENC, DEC, ENC, DEC; o_eng_mode_sel=0,1,0,1.
- Engine never pulses done, TIMEOUT=64 → RESP after 64 RUN cycles, rsp_err=1, rsp_data=0, next job runs normally.
- rsp_ready held low 10 cycles → rsp_valid and data stable, both req_ready stay 0, accept occurs the cycle after the handshake.
- rst pulsed low during ENC_RUN bit 7 → all outputs at reset values, no response issued; a following request completes correctly.

Source files
------------

// File: rtl/endec_sched_pkg.sv
// Shared definitions for the endec scheduler: engine mode codes, FSM state
// encodings and default frame geometry matching the engine's parameters.
package endec_sched_pkg;

  // Defaults track DATA_FRAME_LENGTH, MAX_CODE_RATE and TRACEBACK_DEPTH of the engine
  localparam int FRAME_LEN_DEF = 16;
  localparam int CODE_RATE_DEF = 2;
  localparam int TB_DEPTH_DEF  = FRAME_LEN_DEF * CODE_RATE_DEF;
  localparam int TIMEOUT_DEF   = 64;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_ENC_RUN = 3'd2,
    ST_DEC_RUN = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/endec_sched_arb.sv
// Two-way round-robin arbiter between the encode and decode requesters.
// Ready is only offered while the scheduler is idle, to the granted side.
module endec_sched_arb
  import endec_sched_pkg::*;
(
  input  logic sys_clk,
  input  logic rst,
  input  logic i_idle,
  input  logic i_enc_valid,
  input  logic i_dec_valid,
  output logic o_enc_ready,
  output logic o_dec_ready,
  output logic o_accept,
  output logic o_accept_mode
);

  logic r_last_grant;
  logic w_grant;

  // Contention flips away from the previous winner; otherwise the lone requester wins
  assign w_grant     = (i_enc_valid && i_dec_valid) ? ~r_last_grant : i_dec_valid;
  assign o_enc_ready = i_idle && i_enc_valid && (w_grant == MODE_ENC);
  assign o_dec_ready = i_idle && i_dec_valid && (w_grant == MODE_DEC);
  assign o_accept      = o_enc_ready || o_dec_ready;
  assign o_accept_mode = w_grant;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst)          r_last_grant <= MODE_DEC;
    else if (o_accept) r_last_grant <= w_grant;
  end

endmodule

// File: rtl/endec_sched.sv
// Scheduler sharing one endec engine between encode and decode requesters:
// arbitrate, flush the engine, run the job under a timeout, hold the response.
module endec_sched
  import endec_sched_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CODE_RATE = CODE_RATE_DEF,
  parameter int TB_DEPTH  = TB_DEPTH_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                           sys_clk,
  input  logic                           rst,
  input  logic                           i_enc_req_valid,
  output logic                           o_enc_req_ready,
  input  logic [FRAME_LEN-1:0]           i_enc_req_data,
  output logic                           o_enc_rsp_valid,
  input  logic                           i_enc_rsp_ready,
  output logic [FRAME_LEN*CODE_RATE-1:0] o_enc_rsp_data,
  output logic                           o_enc_rsp_err,
  input  logic                           i_dec_req_valid,
  output logic                           o_dec_req_ready,
  input  logic [TB_DEPTH-1:0]            i_dec_req_data,
  output logic                           o_dec_rsp_valid,
  input  logic                           i_dec_rsp_ready,
  output logic [FRAME_LEN-1:0]           o_dec_rsp_data,
  output logic                           o_dec_rsp_err,
  output logic                           o_eng_rst_n,
  output logic                           o_eng_en,
  output logic                           o_eng_mode_sel,
  output logic                           o_eng_encoder_bit,
  output logic [TB_DEPTH-1:0]            o_eng_decoder_data_frame,
  input  logic [CODE_RATE-1:0]           i_eng_encoder_data,
  input  logic                           i_eng_encoder_done,
  input  logic [FRAME_LEN-1:0]           i_eng_decoder_data,
  input  logic                           i_eng_decoder_done,
  output logic                           o_busy
);

  localparam int ENC_W = FRAME_LEN * CODE_RATE;
  localparam int IDX_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t               r_state, w_next;
  logic [FRAME_LEN-1:0] r_payload;
  logic [TB_DEPTH-1:0]  r_frame;
  logic [ENC_W-1:0]     r_enc_rsp;
  logic [FRAME_LEN-1:0] r_dec_rsp;
  logic                 r_err;
  logic                 r_mode;
  logic [IDX_W-1:0]     r_idx;
  logic [TMR_W-1:0]     r_timer;

  logic w_idle, w_accept, w_accept_mode;
  logic w_enc_done, w_dec_done, w_timeout, w_last_bit, w_rsp_ready;
  logic [IDX_W-1:0] w_bit_sel;

  assign w_idle = (r_state == ST_IDLE);

  endec_sched_arb u_arb (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .i_idle        (w_idle),
    .i_enc_valid   (i_enc_req_valid),
    .i_dec_valid   (i_dec_req_valid),
    .o_enc_ready   (o_enc_req_ready),
    .o_dec_ready   (o_dec_req_ready),
    .o_accept      (w_accept),
    .o_accept_mode (w_accept_mode)
  );

  // Done pulses only count in the RUN state of the matching mode
  assign w_enc_done  = (r_state == ST_ENC_RUN) && i_eng_encoder_done;
  assign w_dec_done  = (r_state == ST_DEC_RUN) && i_eng_decoder_done;
  assign w_timeout   = (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_last_bit  = (r_idx == IDX_W'(FRAME_LEN - 1));
  assign w_rsp_ready = (r_mode == MODE_DEC) ? i_dec_rsp_ready : i_enc_rsp_ready;
  assign w_bit_sel   = IDX_W'(FRAME_LEN - 1) - r_idx;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next = ST_FLUSH;
      ST_FLUSH:   w_next = (r_mode == MODE_DEC) ? ST_DEC_RUN : ST_ENC_RUN;
      ST_ENC_RUN: if (w_enc_done ? w_last_bit : w_timeout) w_next = ST_RESP;
      ST_DEC_RUN: if (w_dec_done || w_timeout) w_next = ST_RESP;
      ST_RESP:    if (w_rsp_ready) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_payload <= '0;
      r_frame   <= '0;
      r_enc_rsp <= '0;
      r_dec_rsp <= '0;
      r_err     <= 1'b0;
      r_mode    <= 1'b0;
      r_idx     <= '0;
      r_timer   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_mode  <= w_accept_mode;
          r_err   <= 1'b0;
          r_idx   <= '0;
          r_timer <= '0;
          if (w_accept_mode == MODE_DEC) begin
            r_frame   <= i_dec_req_data;
            r_dec_rsp <= '0;
          end else begin
            r_payload <= i_enc_req_data;
            r_enc_rsp <= '0;
          end
        end
        ST_ENC_RUN: begin
          // A done in the timeout cycle still counts: done is checked first
          if (w_enc_done) begin
            r_enc_rsp <= {r_enc_rsp[ENC_W-CODE_RATE-1:0], i_eng_encoder_data};
            r_idx     <= r_idx + IDX_W'(1);
            r_timer   <= '0;
          end else if (w_timeout) begin
            r_err     <= 1'b1;
            r_enc_rsp <= '0;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_DEC_RUN: begin
          if (w_dec_done) begin
            r_dec_rsp <= i_eng_decoder_data;
            r_timer   <= '0;
          end else if (w_timeout) begin
            r_err     <= 1'b1;
            r_dec_rsp <= '0;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_busy            = (r_state != ST_IDLE);
    o_eng_en          = (r_state == ST_ENC_RUN) || (r_state == ST_DEC_RUN);
    o_eng_rst_n       = rst && (r_state != ST_FLUSH);
    o_eng_encoder_bit = 1'b0;
    if (r_state == ST_ENC_RUN) o_eng_encoder_bit = r_payload[w_bit_sel];
    o_enc_rsp_valid   = (r_state == ST_RESP) && (r_mode == MODE_ENC);
    o_dec_rsp_valid   = (r_state == ST_RESP) && (r_mode == MODE_DEC);
    o_enc_rsp_err     = r_err && (r_mode == MODE_ENC);
    o_dec_rsp_err     = r_err && (r_mode == MODE_DEC);
  end

  assign o_eng_mode_sel           = r_mode;
  assign o_eng_decoder_data_frame = r_frame;
  assign o_enc_rsp_data           = r_enc_rsp;
  assign o_dec_rsp_data           = r_dec_rsp;

endmodule

// File: tb/tb_endec_sched.sv
// Directed + randomized bench for endec_sched with a behavioural engine model
// and an arithmetic reference for coded data, latency and timeout results.
module tb_endec_sched;

  localparam int FL = 16;
  localparam int CR = 2;
  localparam int TD = 32;
  localparam int TO = 64;

  logic          sys_clk, rst;
  logic          i_enc_req_valid, o_enc_req_ready;
  logic [FL-1:0] i_enc_req_data;
  logic          o_enc_rsp_valid, i_enc_rsp_ready;
  logic [FL*CR-1:0] o_enc_rsp_data;
  logic          o_enc_rsp_err;
  logic          i_dec_req_valid, o_dec_req_ready;
  logic [TD-1:0] i_dec_req_data;
  logic          o_dec_rsp_valid, i_dec_rsp_ready;
  logic [FL-1:0] o_dec_rsp_data;
  logic          o_dec_rsp_err;
  logic          o_eng_rst_n, o_eng_en, o_eng_mode_sel, o_eng_encoder_bit;
  logic [TD-1:0] o_eng_decoder_data_frame;
  logic [CR-1:0] i_eng_encoder_data;
  logic          i_eng_encoder_done;
  logic [FL-1:0] i_eng_decoder_data;
  logic          i_eng_decoder_done;
  logic          o_busy;

  int n_chk = 0;
  int n_fail = 0;

  endec_sched #(.FRAME_LEN(FL), .CODE_RATE(CR), .TB_DEPTH(TD), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .i_enc_req_valid(i_enc_req_valid), .o_enc_req_ready(o_enc_req_ready),
    .i_enc_req_data(i_enc_req_data), .o_enc_rsp_valid(o_enc_rsp_valid),
    .i_enc_rsp_ready(i_enc_rsp_ready), .o_enc_rsp_data(o_enc_rsp_data),
    .o_enc_rsp_err(o_enc_rsp_err),
    .i_dec_req_valid(i_dec_req_valid), .o_dec_req_ready(o_dec_req_ready),
    .i_dec_req_data(i_dec_req_data), .o_dec_rsp_valid(o_dec_rsp_valid),
    .i_dec_rsp_ready(i_dec_rsp_ready), .o_dec_rsp_data(o_dec_rsp_data),
    .o_dec_rsp_err(o_dec_rsp_err),
    .o_eng_rst_n(o_eng_rst_n), .o_eng_en(o_eng_en), .o_eng_mode_sel(o_eng_mode_sel),
    .o_eng_encoder_bit(o_eng_encoder_bit),
    .o_eng_decoder_data_frame(o_eng_decoder_data_frame),
    .i_eng_encoder_data(i_eng_encoder_data), .i_eng_encoder_done(i_eng_encoder_done),
    .i_eng_decoder_data(i_eng_decoder_data), .i_eng_decoder_done(i_eng_decoder_done),
    .o_busy(o_busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Engine model: done after eng_gap+1 enabled cycles, coded pair is {b,~b}
  logic [7:0]  eng_cnt;
  int          eng_gap = 0;
  bit          eng_mute = 0;
  bit          spur = 0;
  logic [15:0] dec_word = '0;
  logic        w_hit;

  always_ff @(posedge sys_clk) begin
    if (!o_eng_en) eng_cnt <= '0;
    else if (i_eng_encoder_done || i_eng_decoder_done) eng_cnt <= '0;
    else eng_cnt <= eng_cnt + 8'd1;
  end
  assign w_hit = o_eng_en && !eng_mute && (int'(eng_cnt) == eng_gap);
  assign i_eng_encoder_done = spur || (w_hit && !o_eng_mode_sel);
  assign i_eng_decoder_done = spur || (w_hit && o_eng_mode_sel);
  assign i_eng_encoder_data = {o_eng_encoder_bit, ~o_eng_encoder_bit};
  assign i_eng_decoder_data = dec_word;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_ref(input logic [15:0] p);
    logic [31:0] r = '0;
    for (int i = 15; i >= 0; i--) r = {r[29:0], p[i], ~p[i]};
    return r;
  endfunction

  function automatic logic rsp_v(input bit dec);
    return dec ? o_dec_rsp_valid : o_enc_rsp_valid;
  endfunction

  // One job from request to handshake; called and returns on a negedge
  task automatic run_job(input bit dec, input logic [31:0] data, input int gap,
                         input int stall, input bit mute, input logic [15:0] dword,
                         input bit pend);
    int cyc, lat, nflush, exp_lat;
    logic [31:0] exp_d;
    eng_gap = gap; eng_mute = mute; dec_word = dword;
    if (dec) begin
      exp_d   = mute ? 32'h0 : {16'h0, dword};
      exp_lat = mute ? 2 + TO : 3 + gap;
      i_dec_req_valid = 1'b1; i_dec_req_data = data;
    end else begin
      exp_d   = mute ? 32'h0 : enc_ref(data[15:0]);
      exp_lat = mute ? 2 + TO : 2 + FL * (gap + 1);
      i_enc_req_valid = 1'b1; i_enc_req_data = data[15:0];
    end
    #1;
    cyc = 0;
    while (!(dec ? o_dec_req_ready : o_enc_req_ready) && cyc < 200) begin
      @(negedge sys_clk); cyc++;
    end
    chk("accept_seen", 64'(cyc < 200), 64'd1);
    @(posedge sys_clk); #1;
    if (dec) i_dec_req_valid = 1'b0; else i_enc_req_valid = 1'b0;
    lat = 0; nflush = 0;
    do begin
      @(negedge sys_clk); lat++;
      if (!o_eng_rst_n) nflush++;
    end while (!rsp_v(dec) && lat < 300);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("flush_cycles", 64'(nflush), 64'd1);
    chk("rsp_data", dec ? {48'h0, o_dec_rsp_data} : {32'h0, o_enc_rsp_data}, {32'h0, exp_d});
    chk("rsp_err", dec ? o_dec_rsp_err : o_enc_rsp_err, 64'(mute));
    chk("other_valid", dec ? o_enc_rsp_valid : o_dec_rsp_valid, 64'd0);
    chk("mode_sel", o_eng_mode_sel, 64'(dec));
    if (dec) chk("dec_frame", o_eng_decoder_data_frame, {32'h0, data});
    if (pend) begin
      if (dec) i_enc_req_valid = 1'b1; else i_dec_req_valid = 1'b1;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge sys_clk);
      chk("stall_valid", rsp_v(dec), 64'd1);
      chk("stall_data", dec ? {48'h0, o_dec_rsp_data} : {32'h0, o_enc_rsp_data}, {32'h0, exp_d});
      chk("stall_readies", {o_enc_req_ready, o_dec_req_ready}, 64'd0);
    end
    if (dec) i_dec_rsp_ready = 1'b1; else i_enc_rsp_ready = 1'b1;
    @(negedge sys_clk);
    i_dec_rsp_ready = 1'b0; i_enc_rsp_ready = 1'b0;
    chk("rsp_dropped", rsp_v(dec), 64'd0);
    chk("mode_hold", o_eng_mode_sel, 64'(dec));
    if (pend) chk("pend_ready_next", dec ? o_enc_req_ready : o_dec_req_ready, 64'd1);
  endtask

  initial begin
    int n;
    logic [15:0] pl;
    bit saw_rsp;
    rst = 1'b0;
    i_enc_req_valid = 0; i_enc_req_data = '0; i_enc_rsp_ready = 0;
    i_dec_req_valid = 0; i_dec_req_data = '0; i_dec_rsp_ready = 0;
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_eng_rst_n", o_eng_rst_n, 0);
    chk("rst_eng", {o_eng_en, o_eng_mode_sel, o_eng_encoder_bit}, 0);
    chk("rst_valids", {o_enc_rsp_valid, o_dec_rsp_valid, o_enc_req_ready, o_dec_req_ready}, 0);
    chk("rst_data", {o_enc_rsp_data, o_dec_rsp_data}, 0);
    chk("rst_frame", o_eng_decoder_data_frame, 0);
    rst = 1'b1;
    @(negedge sys_clk);
    chk("eng_rst_n_released", o_eng_rst_n, 1);

    // Directed encode and decode from the plan
    run_job(0, 32'hA5C3, 0, 0, 0, 16'h0, 0);
    run_job(1, 32'hCAFE_F00D, 4, 0, 0, 16'h1234, 0);

    // Spurious done pulses while idle are ignored
    spur = 1; @(negedge sys_clk); spur = 0;
    chk("spur_busy", o_busy, 0);
    chk("spur_valids", {o_enc_rsp_valid, o_dec_rsp_valid}, 0);

    // Timeouts, then normal jobs
    run_job(0, 32'h1357, 0, 1, 1, 16'h0, 0);
    run_job(0, 32'h00FF, 1, 0, 0, 16'h0, 0);
    run_job(1, 32'h1111_2222, 0, 0, 1, 16'hBEEF, 0);
    run_job(1, 32'h3333_4444, 2, 0, 0, 16'h5A5A, 0);

    // Stalled response with a pending decode, then that decode runs
    i_dec_req_data = 32'hDEAD_BEEF;
    run_job(0, 32'h8001, 0, 10, 0, 16'h0, 1);
    run_job(1, 32'hDEAD_BEEF, 1, 0, 0, 16'h7E57, 0);

    // Reset pulsed while bit 7 is on the engine
    eng_gap = 0; eng_mute = 0;
    pl = 16'hB6E1;
    i_enc_req_valid = 1; i_enc_req_data = pl; #1;
    n = 0;
    while (!o_enc_req_ready && n < 50) begin @(negedge sys_clk); n++; end
    chk("midrst_accept", 64'(n < 50), 1);
    @(posedge sys_clk); #1; i_enc_req_valid = 0;
    repeat (9) @(negedge sys_clk);
    chk("midrst_bit7", o_eng_encoder_bit, 64'(pl[8]));
    rst = 1'b0; #1;
    chk("midrst_busy", o_busy, 0);
    chk("midrst_eng", {o_eng_rst_n, o_eng_en, o_eng_mode_sel, o_eng_encoder_bit}, 0);
    chk("midrst_out", {o_enc_rsp_valid, o_dec_rsp_valid, o_enc_rsp_err, o_dec_rsp_err}, 0);
    chk("midrst_data", {o_enc_rsp_data, o_dec_rsp_data}, 0);
    @(negedge sys_clk); rst = 1'b1;
    saw_rsp = 0;
    repeat (20) begin @(negedge sys_clk); if (o_enc_rsp_valid || o_dec_rsp_valid || o_busy) saw_rsp = 1; end
    chk("midrst_no_rsp", 64'(saw_rsp), 0);
    run_job(0, 32'h0F0F, 0, 2, 0, 16'h0, 0);

    // Both requesters held from reset: grants alternate starting with encode
    @(negedge sys_clk); rst = 1'b0;
    i_enc_req_valid = 1; i_enc_req_data = 16'h4242;
    i_dec_req_valid = 1; i_dec_req_data = 32'h0;
    i_enc_rsp_ready = 1; i_dec_rsp_ready = 1;
    eng_gap = 0; eng_mute = 0; dec_word = 16'h9999;
    @(negedge sys_clk); rst = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(o_enc_req_ready || o_dec_req_ready) && n < 100) begin @(negedge sys_clk); n++; end
      chk("alt_enc_ready", o_enc_req_ready, 64'(k % 2 == 0));
      chk("alt_dec_ready", o_dec_req_ready, 64'(k % 2 == 1));
      @(negedge sys_clk);
      chk("alt_mode", o_eng_mode_sel, 64'(k % 2));
    end
    i_enc_req_valid = 0; i_dec_req_valid = 0;
    n = 0;
    while (o_busy && n < 100) begin @(negedge sys_clk); n++; end
    chk("alt_drain", o_busy, 0);
    i_enc_rsp_ready = 0; i_dec_rsp_ready = 0;

    // Randomized jobs
    for (int j = 0; j < 12; j++) begin
      run_job(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 5) == 0), 16'($urandom), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
